// File: rtl/aes_shiftrows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shiftrows_pipe
//
// Pipelined ShiftRows / InvShiftRows unit shared by the AES encrypt and
// decrypt datapaths. The selected row permutation is applied combinationally
// in front of the first register stage. The beat then moves through
// PIPE_STAGES register stages under full valid/ready flow control.
//
// Parameters
//   PIPE_STAGES  number of register stages (1..4), equal to the latency
//   TAG_W        width of the sideband tag carried with each beat (1..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream beat valid
//   in_ready   unit accepts a beat this cycle
//   in_inv     0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
//   in_bypass  (only with AES_SR_BYPASS_EN) load in_state unpermuted
//   in_state   AES state, byte k at bits [127-8k -: 8]
//   in_tag     sideband tag, passed through unmodified
//   out_valid  result beat valid
//   out_ready  downstream accepts the beat
//   out_state  permuted state
//   out_tag    tag of the result beat
//   occupancy  number of valid beats held in the pipeline
//
// Optional feature macro: AES_SR_BYPASS_EN (adds the in_bypass port).
// ---------------------------------------------------------------------------
module aes_shiftrows_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
`ifdef AES_SR_BYPASS_EN
    input  logic             in_bypass,
`endif
    input  logic [127:0]     in_state,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       occupancy
);

    localparam int LAST = PIPE_STAGES - 1;

    // Byte k sits at row k mod 4, column k div 4. Row r rotates left by r
    // columns for the forward transform and right by r for the inverse.
    function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                                input logic         inv);
        logic [127:0] r_s;
        int           src;
        r_s = s;
        for (int row = 1; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src = inv ? ((col - row + 4) % 4) : ((col + row) % 4);
                r_s[127 - 8*(4*col + row) -: 8] = s[127 - 8*(4*src + row) -: 8];
            end
        end
        return r_s;
    endfunction

    logic [PIPE_STAGES-1:0] vld_p;
    logic [127:0]           state_p [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_p   [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] up_vld;
    logic [127:0]           up_state [PIPE_STAGES];
    logic [TAG_W-1:0]       up_tag   [PIPE_STAGES];
    logic [127:0]           in_perm;
    logic                   in_fire;
    logic                   out_fire;

    // Input side: permutation ahead of stage 1
`ifdef AES_SR_BYPASS_EN
    assign in_perm = in_bypass ? in_state : shift_rows(in_state, in_inv);
`else
    assign in_perm = shift_rows(in_state, in_inv);
`endif

    // Ready chain: a stage can load when it is empty or its beat moves on.
    // Unrolled, that is: out_ready, or any stage at or after this one is
    // empty. Computing it that way keeps the chain free of self-reference.
    always_comb begin
        logic chain;
        load  = '0;
        chain = out_ready;
        for (int i = LAST; i >= 0; i--) begin
            chain   = chain | ~vld_p[i];
            load[i] = chain;
        end
    end

    // Source of each stage: the permuted input for stage 1, the previous
    // stage for the rest.
    always_comb begin
        up_vld      = '0;
        up_vld[0]   = in_valid;
        up_state[0] = in_perm;
        up_tag[0]   = in_tag;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            up_vld[i]   = vld_p[i-1];
            up_state[i] = state_p[i-1];
            up_tag[i]   = tag_p[i-1];
        end
    end

    assign in_ready  = load[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = vld_p[LAST] & out_ready;

    // Register stages 1..PIPE_STAGES. Data only moves when a valid beat
    // arrives, so a drained stage keeps its last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                state_p[i] <= '0;
                tag_p[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (load[i]) begin
                    vld_p[i] <= up_vld[i];
                    if (up_vld[i]) begin
                        state_p[i] <= up_state[i];
                        tag_p[i]   <= up_tag[i];
                    end
                end
            end
        end
    end

    // Output side
    assign out_valid = vld_p[LAST];
    assign out_state = state_p[LAST];
    assign out_tag   = tag_p[LAST];

    // Occupancy: simultaneous input and output transfers cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= 3'd0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_shiftrows_pipe
//
// Directed bench for aes_shiftrows_pipe (PIPE_STAGES = 2, TAG_W = 4).
// A scoreboard queue holds the expected state/tag of every accepted beat
// and is checked, in order, against every beat the unit delivers. The
// reference permutation rotates a 4x4 byte matrix row by row.
// With AES_SR_BYPASS_EN defined the bypass port is connected and exercised.
// ---------------------------------------------------------------------------
module tb_aes_shiftrows_pipe;

    localparam int P  = 2;
    localparam int TW = 4;

    localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] VEC_INV = 128'h000d0a0704010e0b0805020f0c090603;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_inv;
`ifdef AES_SR_BYPASS_EN
    logic          in_bypass;
`endif
    logic [127:0]  in_state;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_state;
    logic [TW-1:0] out_tag;
    logic [2:0]    occupancy;

    typedef struct packed {
        logic [127:0]  st;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   pops;

    always #5 clk = ~clk;

    aes_shiftrows_pipe #(.PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
`ifdef AES_SR_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .in_state  (in_state),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    // Reference: unpack into a matrix, rotate row r by r single steps.
    function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
        logic [7:0]   m [4][4];
        logic [7:0]   t;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127 - 8*(4*c + r) -: 8];
        for (int r = 1; r < 4; r++) begin
            for (int n = 0; n < r; n++) begin
                if (!inv) begin
                    t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2];
                    m[r][2] = m[r][3]; m[r][3] = t;
                end else begin
                    t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1];
                    m[r][1] = m[r][0]; m[r][0] = t;
                end
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = m[r][c];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop/compare on output transfer, push on input transfer.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_state", out_state, e.st);
                    chk("sb_tag", out_tag, e.tag);
                    pops++;
                end
            end
            if (!rst && in_valid && in_ready) begin
`ifdef AES_SR_BYPASS_EN
                e.st = in_bypass ? in_state : ref_sr(in_state, in_inv);
`else
                e.st = ref_sr(in_state, in_inv);
`endif
                e.tag = in_tag;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [127:0] s, input logic inv, input logic [TW-1:0] tag);
        logic got;
        got      = 1'b0;
        in_state = s;
        in_inv   = inv;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        in_valid = 1'b0;
        chk("send_handshake", 128'(got), 128'd1);
    endtask

    task automatic recv(output logic [127:0] st);
        logic got;
        got = 1'b0;
        st  = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                st  = out_state;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("recv_handshake", 128'(got), 128'd1);
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] r1;
        logic [127:0] r2;
        logic         inv;
        int           base;
        int           run;
        time          t0;

        total     = 0;
        bad       = 0;
        pops      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_state  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef AES_SR_BYPASS_EN
        in_bypass = 1'b0;
`endif
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog observed=timeout expected=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_out_tag", out_tag, 128'd0);
        chk("rst_occupancy", occupancy, 128'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 128'd1);

        // Forward vector with latency check
        send(VEC_IN, 1'b0, 4'h3);
        for (int k = 0; k < P - 1; k++) begin
            chk("fwd_early", out_valid, 128'd0);
            @(posedge clk);
            #1;
        end
        chk("fwd_valid", out_valid, 128'd1);
        chk("fwd_state", out_state, VEC_FWD);
        chk("fwd_tag", out_tag, 128'h3);
        @(posedge clk);
        #1;
        chk("fwd_drained", out_valid, 128'd0);

        // Inverse vector
        send(VEC_IN, 1'b1, 4'h5);
        for (int k = 0; k < P - 1; k++) begin
            @(posedge clk);
            #1;
        end
        chk("inv_valid", out_valid, 128'd1);
        chk("inv_state", out_state, VEC_INV);
        chk("inv_tag", out_tag, 128'h5);
        @(posedge clk);
        #1;

        // Round trip over random states and directions
        for (int i = 0; i < 1000; i++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(s, inv, 4'(i));
            recv(r1);
            send(r1, !inv, 4'(i + 1));
            recv(r2);
            chk("roundtrip", r2, s);
        end

        // Back-pressure: 8 beats, out_ready low for 5 cycles
        base      = pops;
        out_ready = 1'b0;
        fork
            begin
                for (int j = 0; j < 8; j++)
                    send({$urandom, $urandom, $urandom, $urandom}, 1'(j), 4'(j + 8));
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("bp_occ_full", occupancy, 128'(P));
                chk("bp_in_ready_low", in_ready, 128'd0);
                chk("bp_out_held", out_valid, 128'd1);
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (occupancy == 3'd0 && sb.size() == 0) break;
        end
        chk("bp_occ_zero", occupancy, 128'd0);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);
        chk("bp_count", 128'(pops - base), 128'd8);

        // Throughput: 16 back-to-back beats, alternating direction
        base = pops;
        run  = 0;
        t0   = $time;
        fork
            begin
                for (int j = 0; j < 16; j++)
                    send({$urandom, $urandom, $urandom, $urandom}, 1'(j), 4'(j));
                chk("thru_accept_time", 128'($time - t0), 128'd160);
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                for (int k = 0; k < 16; k++) begin
                    if (out_valid) run++;
                    @(negedge clk);
                end
                chk("thru_run", 128'(run), 128'd16);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("thru_count", 128'(pops - base), 128'd16);

        // Reset mid-stream with two beats in flight
        out_ready = 1'b0;
        send(VEC_IN, 1'b0, 4'h1);
        send(VEC_IN, 1'b1, 4'h2);
        chk("mid_occ_two", occupancy, 128'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 128'd0);
        chk("mid_rst_occ", occupancy, 128'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_in_ready", in_ready, 128'd1);
        out_ready = 1'b1;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, 4'hA);
        for (int k = 0; k < P - 1; k++) begin
            chk("mid_early", out_valid, 128'd0);
            @(posedge clk);
            #1;
        end
        chk("mid_valid", out_valid, 128'd1);
        chk("mid_state", out_state, ref_sr(s, 1'b0));
        chk("mid_tag", out_tag, 128'hA);
        @(posedge clk);
        #1;

`ifdef AES_SR_BYPASS_EN
        // Bypassed beat passes through unchanged
        in_bypass = 1'b1;
        send(VEC_IN, 1'b1, 4'h7);
        in_bypass = 1'b0;
        recv(r1);
        chk("bypass_state", r1, VEC_IN);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("final_sb_empty", 128'(sb.size()), 128'd0);
        chk("final_occ", occupancy, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
